comparator_bist: RTL

Built-in self-test engine for the magnitude comparator. The comparator is driven by hand-written stimulus today; this block drives it instead. It sweeps every (A, B) operand pair, samples the comparator's three result flags, checks them against an internal golden model, and reports pass/fail, an error count and the first failing vector. It sits beside the comparator instance and owns its A/B inputs.

---
 rtl/comparator_bist_pkg.sv | 35 +++
 rtl/comparator_golden.sv | 25 ++
 rtl/comparator_bist.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/comparator_bist_pkg.sv
// ============================================================================
// Module   : comparator_bist_pkg
// Purpose  : Shared types and constants for the comparator BIST engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package comparator_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit positions inside the 3-bit {gt, eq, lt} flag vector
  localparam int GT    = 2;
  localparam int EQ    = 1;
  localparam int LT    = 0;
  localparam int RES_W = 3;

  function automatic logic [RES_W-1:0] pack_flags(input logic gt, input logic eq,
                                                  input logic lt);
    logic [RES_W-1:0] flags;
    flags     = '0;
    flags[GT] = gt;
    flags[EQ] = eq;
    flags[LT] = lt;
    return flags;
  endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_golden.sv
// ============================================================================
// Module   : comparator_golden
// Purpose  : Combinational reference model giving the one-hot {gt, eq, lt}
//            result expected from a correct magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_golden
  import comparator_bist_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [RES_W-1:0] result
);

  always_comb begin
    result = pack_flags(a > b, a == b, a < b);
  end

endmodule

`default_nettype wire

// File: rtl/comparator_bist.sv
// ============================================================================
// Module   : comparator_bist
// Purpose  : Exhaustive self-test sweep of a WIDTH-bit magnitude comparator;
//            reports pass/fail, a saturating error count and the first
//            failing vector. Optional macro COMPARATOR_BIST_STOP_ON_FAIL_EN
//            ends the sweep at the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_bist
  import comparator_bist_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  input  logic                 AequalsB,
  input  logic                 AgreaterB,
  input  logic                 AlessB,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_fail_a,
  output logic [WIDTH-1:0]     first_fail_b
);

  localparam int                IDX_W    = 2 * WIDTH;
  localparam logic [IDX_W-1:0]  LAST_IDX = {IDX_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    idx;
  logic [RES_W-1:0]    expected;
  logic [RES_W-1:0]    observed;
  logic                mismatch;
  logic                clear;
  logic                advance;
  logic                finish;
  logic [ERR_CNT_W-1:0] err_q;
  logic [WIDTH-1:0]    ffa_q;
  logic [WIDTH-1:0]    ffb_q;
  logic                pass_q;

  // A is the outer loop (upper half of idx), B the inner loop
  assign A = idx[IDX_W-1:WIDTH];
  assign B = idx[WIDTH-1:0];

  comparator_golden #(
    .WIDTH (WIDTH)
  ) u_golden (
    .a      (A),
    .b      (B),
    .result (expected)
  );

  assign observed = pack_flags(AgreaterB, AequalsB, AlessB);
  assign mismatch = (observed != expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = DRIVE;
          clear      = 1'b1;
        end
      end
      DRIVE: begin
        state_next = CHECK;
      end
      CHECK: begin
        if ((idx == LAST_IDX) || (STOP_ON_FAIL && mismatch)) begin
          state_next = DONE;
          finish     = 1'b1;
        end else begin
          state_next = DRIVE;
          advance    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      err_q  <= '0;
      ffa_q  <= '0;
      ffb_q  <= '0;
      pass_q <= 1'b0;
    end else if (clear) begin
      idx    <= '0;
      err_q  <= '0;
      ffa_q  <= '0;
      ffb_q  <= '0;
      pass_q <= 1'b0;
    end else if (state == CHECK) begin
      if (mismatch) begin
        if (err_q != ERR_MAX) begin
          err_q <= err_q + 1'b1;
        end
        if (err_q == '0) begin
          ffa_q <= A;
          ffb_q <= B;
        end
      end
      if (advance) begin
        idx <= idx + 1'b1;
      end
      if (finish) begin
        pass_q <= (err_q == '0) && !mismatch;
      end
    end
  end

  assign busy         = (state == DRIVE) || (state == CHECK);
  assign done         = (state == DONE);
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign first_fail_a = ffa_q;
  assign first_fail_b = ffb_q;

endmodule

`default_nettype wire
